// File: rtl/serial_full_subtractor.sv
// Bit-serial LSB-first D=A-B; a beat accepted at edge N is on the outputs after edge N+PIPE_DEPTH-1.
// A held output (out_valid && !out_ready) freezes pipe and borrow, in_ready drops; SERIAL_SUB_OVF_EN adds ovf.
module serial_full_subtractor #(
  parameter int PIPE_DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_first,
  input  logic in_last,
  input  logic a,
  input  logic b,
  output logic out_valid,
  input  logic out_ready,
  output logic out_first,
  output logic out_last,
  output logic d,
  output logic bout,
  output logic err
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic ovf
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic vld;
    logic d;
    logic bout;
    logic first;
    logic last;
`ifdef SERIAL_SUB_OVF_EN
    logic ovf;
`endif
  } stage_t;

  state_t state_q, state_d;
  logic   br_q, br_d;
  logic   err_q, err_d;
  stage_t pipe_q [PIPE_DEPTH];
  stage_t stage0;
  logic   stall, accept, lead, bin, bnext;

  assign stall    = pipe_q[PIPE_DEPTH-1].vld && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // A beat arriving with no word open is treated as the LSB so its borrow-in is 0.
  always_comb begin
    state_d = state_q;
    br_d    = br_q;
    err_d   = err_q;
    stage0  = '0;
    lead    = in_first || (state_q == IDLE);
    bin     = lead ? 1'b0 : br_q;
    bnext   = (~a & b) | (~(a ^ b) & bin);
    if (accept) begin
      stage0.vld   = 1'b1;
      stage0.d     = a ^ b ^ bin;
      stage0.bout  = in_last & bnext;
      stage0.first = in_first;
      stage0.last  = in_last;
`ifdef SERIAL_SUB_OVF_EN
      stage0.ovf   = in_last & (bin ^ bnext);
`endif
      if (in_first ? (state_q == BUSY) : (state_q == IDLE)) begin
        err_d = 1'b1;
      end
      if (in_last) begin
        state_d = IDLE;
        br_d    = 1'b0;
      end else begin
        state_d = BUSY;
        br_d    = bnext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      br_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      err_q   <= err_d;
    end
  end

  // Bubbles shift along with data so every beat sees the same fixed latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (!stall) begin
      pipe_q[0] <= stage0;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign out_valid = pipe_q[PIPE_DEPTH-1].vld;
  assign out_first = pipe_q[PIPE_DEPTH-1].first;
  assign out_last  = pipe_q[PIPE_DEPTH-1].last;
  assign d         = pipe_q[PIPE_DEPTH-1].d;
  assign bout      = pipe_q[PIPE_DEPTH-1].bout;
  assign err       = err_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = pipe_q[PIPE_DEPTH-1].ovf;
`endif

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed bench for serial_full_subtractor: arithmetic, latency, backpressure, framing and reset flush.
module tb_serial_full_subtractor;
  localparam int P = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, a = 1'b0, b = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_first, out_last, d, bout, err, ovf;

  typedef struct packed {
    logic [31:0] cyc;
    logic d;
    logic bout;
    logic first;
    logic last;
    logic ovf;
  } rbeat_t;

  rbeat_t rq[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int last_acc = 0;
  int word_acc = 0;

  serial_full_subtractor #(.PIPE_DEPTH(P)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
    .d(d), .bout(bout), .err(err)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every beat that will be consumed at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      rq.push_back(rbeat_t'({32'(cyc), d, bout, out_first, out_last, ovf}));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic aa, input logic bb, input logic f, input logic l);
    bit acc = 1'b0;
    in_valid = 1'b1; a = aa; b = bb; in_first = f; in_last = l;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        last_acc = cyc + 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout observed=no_accept expected=accept");
    end
  endtask

  task automatic send_word(input logic [3:0] av, input logic [3:0] bv);
    for (int i = 0; i < 4; i++) begin
      send(av[i], bv[i], i == 0, i == 3);
      if (i == 0) word_acc = last_acc;
    end
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 500 && rq.size() < n; k++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rq.delete();
  endtask

  task automatic check_word(input string tag, input logic [3:0] ed, input logic eb,
                            input logic eo, input bit lat);
    logic [3:0] dv, bv, fv, lv, ov;
    rbeat_t r;
    int c0 = 0;
    chk({tag, "_count"}, 32'(rq.size() >= 4), 32'd1);
    if (rq.size() < 4) return;
    for (int i = 0; i < 4; i++) begin
      r = rq.pop_front();
      dv[i] = r.d; bv[i] = r.bout; fv[i] = r.first; lv[i] = r.last; ov[i] = r.ovf;
      if (i == 0) c0 = int'(r.cyc);
    end
    chk({tag, "_d"}, 32'(dv), 32'(ed));
    chk({tag, "_bout"}, 32'(bv), 32'({eb, 3'b000}));
    chk({tag, "_first"}, 32'(fv), 32'd1);
    chk({tag, "_last"}, 32'(lv), 32'd8);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ov), 32'({eo, 3'b000}));
`endif
    if (lat) chk({tag, "_latency"}, 32'(c0), 32'(word_acc + P - 1));
  endtask

  initial begin
    // Reset with a beat presented; it must be discarded.
    in_valid = 1'b1; a = 1'b1; in_first = 1'b1; in_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_out_first", 32'(out_first), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; a = 1'b0; in_first = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    repeat (P + 2) begin @(posedge clk); #1; end
    chk("rst_beat_discarded", 32'(rq.size()), 32'd0);

    // 6-3 = 3, with first-result latency
    send_word(4'd6, 4'd3);
    wait_beats(4);
    check_word("sub_6_3", 4'd3, 1'b0, 1'b0, 1'b1);
    chk("err_clean", 32'(err), 32'd0);

    // 3-5 = 14 (signed -2), borrow out
    send_word(4'd3, 4'd5);
    wait_beats(4);
    check_word("sub_3_5", 4'd14, 1'b1, 1'b0, 1'b0);

    // 7-(-1) = 8, borrow and signed overflow
    send_word(4'd7, 4'd15);
    wait_beats(4);
    check_word("sub_7_m1", 4'd8, 1'b1, 1'b1, 1'b0);

    // Backpressure: stall 3 cycles after the 2nd result beat while a new word waits
    send_word(4'd6, 4'd3);
    wait_beats(2);
    out_ready = 1'b0;
    fork
      send_word(4'd6, 4'd3);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_d", 32'(d), 32'd0);
          chk("stall_out_last", 32'(out_last), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_beats(8);
    check_word("bp_word1", 4'd3, 1'b0, 1'b0, 1'b0);
    check_word("bp_word2", 4'd3, 1'b0, 1'b0, 1'b0);

    // Framing: stray non-first beat, then a restart mid-word
    do_reset();
    send(1'b1, 1'b0, 1'b0, 1'b0);
    chk("frame_err_set", 32'(err), 32'd1);
    send_word(4'd3, 4'd5);
    chk("frame_err_sticky", 32'(err), 32'd1);
    wait_beats(5);
    chk("frame_stray_count", 32'(rq.size() >= 5), 32'd1);
    if (rq.size() >= 5) begin
      rbeat_t r;
      r = rq.pop_front();
      chk("frame_stray_d", 32'(r.d), 32'd1);
      chk("frame_stray_first", 32'(r.first), 32'd0);
    end
    check_word("frame_3_5", 4'd14, 1'b1, 1'b0, 1'b0);

    // Reset mid-word flushes the partial word and clears err
    send(1'b0, 1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    send_word(4'd6, 4'd3);
    wait_beats(4);
    check_word("after_rst_6_3", 4'd3, 1'b0, 1'b0, 1'b0);
    repeat (P + 2) begin @(posedge clk); #1; end
    chk("after_rst_no_extra", 32'(rq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
